request_latency_tracker: RTL and testbench

- Upstream stage of the per-request performance logger in the memory controller.
- Owns the free-running global cycle counter and timestamps every accepted request.
- Matches each response to its request in arrival order (the controller returns responses in order) and emits one statistics record per response: request ID, read/write flags, response cycle and latency.
- The logger consumes the record; aggregate counters and error flags are exposed for assertions and debug.

---
 rtl/memctrl_perf_pkg.sv | 22 ++
 rtl/perf_tag_fifo.sv | 59 +++++
 rtl/request_latency_tracker.sv | 115 +++++++++++
 tb/tb_request_latency_tracker.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/memctrl_perf_pkg.sv
// Shared types and default widths for the memory-controller performance logger.
// The entry and record layouts are common to the latency tracker and the logger.
package memctrl_perf_pkg;

  localparam int CYC_W_DEF = 64;
  localparam int LAT_W_DEF = 32;
  localparam int ID_W_DEF  = 32;

  typedef struct packed {
    logic                 is_write;
    logic [CYC_W_DEF-1:0] issue_cycle;
  } perf_entry_t;

  typedef struct packed {
    logic [ID_W_DEF-1:0]  req_id;
    logic                 rd;
    logic                 wr;
    logic [CYC_W_DEF-1:0] cycle;
    logic [LAT_W_DEF-1:0] latency;
  } perf_record_t;

endpackage

// File: rtl/perf_tag_fifo.sv
// Synchronous tag FIFO; full/empty are judged on the state before this cycle's
// push/pop, so a same-cycle pop never frees space for a push when full.
module perf_tag_fifo
  import memctrl_perf_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = CYC_W_DEF + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        pop_data,
  output logic                     full,
  output logic                     empty,
  output logic                     push_ok,
  output logic                     pop_ok,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  // Pop only when non-empty, so rd_ptr never aliases a same-cycle write.
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/request_latency_tracker.sv
// Timestamps accepted requests, matches in-order responses and emits one
// registered statistics record per response, plus debug counters and error flags.
module request_latency_tracker
  import memctrl_perf_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CYC_W = CYC_W_DEF,
  parameter int LAT_W = LAT_W_DEF,
  parameter int ID_W  = ID_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_fire,
  input  logic                   req_is_write,
  input  logic                   resp_fire,
  output logic [CYC_W-1:0]       global_cycle,
  output logic                   stat_valid,
  output logic [ID_W-1:0]        stat_req_id,
  output logic                   stat_rd_en,
  output logic                   stat_wr_en,
  output logic [CYC_W-1:0]       stat_cycle,
  output logic [LAT_W-1:0]       stat_latency,
  output logic [$clog2(DEPTH):0] outstanding,
  output logic [LAT_W-1:0]       max_latency,
  output logic                   err_overflow,
  output logic                   err_underflow
);

  // Clamp a modulo-2^CYC_W age into the latency field.
  function automatic logic [LAT_W-1:0] sat_lat(input logic [CYC_W-1:0] age);
    if (|(age >> LAT_W)) begin
      return '1;
    end
    return LAT_W'(age);
  endfunction

  logic [CYC_W:0]    push_entry;
  logic [CYC_W:0]    pop_entry;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push_ok;
  logic              pop_ok;
  logic [ID_W-1:0]   next_id;

  logic              vld_p0;
  logic              wr_p0;
  logic [CYC_W-1:0]  age_p0;
  logic [LAT_W-1:0]  lat_p0;

  assign push_entry = {req_is_write, global_cycle};

  perf_tag_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (CYC_W + 1)
  ) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (req_fire),
    .push_data (push_entry),
    .pop       (resp_fire),
    .pop_data  (pop_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .push_ok   (push_ok),
    .pop_ok    (pop_ok),
    .count     (outstanding)
  );

  // p0: response cycle, matched entry popped and latency computed
  assign vld_p0 = pop_ok;
  assign wr_p0  = pop_entry[CYC_W];
  assign age_p0 = global_cycle - pop_entry[CYC_W-1:0];
  assign lat_p0 = sat_lat(age_p0);

  // p1: registered record; fields hold between pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      global_cycle  <= '0;
      stat_valid    <= 1'b0;
      stat_req_id   <= '0;
      stat_rd_en    <= 1'b0;
      stat_wr_en    <= 1'b0;
      stat_cycle    <= '0;
      stat_latency  <= '0;
      max_latency   <= '0;
      next_id       <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      global_cycle <= global_cycle + CYC_W'(1);
      stat_valid   <= vld_p0;
      if (vld_p0) begin
        stat_req_id  <= next_id;
        next_id      <= next_id + ID_W'(1);
        stat_rd_en   <= ~wr_p0;
        stat_wr_en   <= wr_p0;
        stat_cycle   <= global_cycle;
        stat_latency <= lat_p0;
        if (lat_p0 > max_latency) begin
          max_latency <= lat_p0;
        end
      end
      if (req_fire && fifo_full) begin
        err_overflow <= 1'b1;
      end
      if (resp_fire && fifo_empty) begin
        err_underflow <= 1'b1;
      end
    end
  end

  logic unused_ok;
  assign unused_ok = push_ok;

endmodule

// File: tb/tb_request_latency_tracker.sv
// Directed bench for request_latency_tracker: default instance plus a LAT_W=4
// instance for latency saturation.
module tb_request_latency_tracker;

  logic        clk;
  logic        reset;
  logic        req_fire, req_is_write, resp_fire;
  logic [63:0] global_cycle, stat_cycle;
  logic        stat_valid, stat_rd_en, stat_wr_en;
  logic [31:0] stat_req_id, stat_latency, max_latency;
  logic [4:0]  outstanding;
  logic        err_overflow, err_underflow;

  logic        s_req_fire, s_req_is_write, s_resp_fire;
  logic [63:0] s_global_cycle, s_stat_cycle;
  logic        s_stat_valid, s_stat_rd_en, s_stat_wr_en;
  logic [31:0] s_stat_req_id;
  logic [3:0]  s_stat_latency, s_max_latency;
  logic [4:0]  s_outstanding;
  logic        s_err_overflow, s_err_underflow;

  int n_pass  = 0;
  int n_total = 0;

  request_latency_tracker dut (
    .clk(clk), .reset(reset), .req_fire(req_fire), .req_is_write(req_is_write),
    .resp_fire(resp_fire), .global_cycle(global_cycle), .stat_valid(stat_valid),
    .stat_req_id(stat_req_id), .stat_rd_en(stat_rd_en), .stat_wr_en(stat_wr_en),
    .stat_cycle(stat_cycle), .stat_latency(stat_latency), .outstanding(outstanding),
    .max_latency(max_latency), .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  request_latency_tracker #(.LAT_W(4)) dut_s (
    .clk(clk), .reset(reset), .req_fire(s_req_fire), .req_is_write(s_req_is_write),
    .resp_fire(s_resp_fire), .global_cycle(s_global_cycle), .stat_valid(s_stat_valid),
    .stat_req_id(s_stat_req_id), .stat_rd_en(s_stat_rd_en), .stat_wr_en(s_stat_wr_en),
    .stat_cycle(s_stat_cycle), .stat_latency(s_stat_latency), .outstanding(s_outstanding),
    .max_latency(s_max_latency), .err_overflow(s_err_overflow), .err_underflow(s_err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the bench at the negedge of the first cycle after reset (global_cycle = 0).
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req_fire = 1'b0; resp_fire = 1'b0; req_is_write = 1'b0;
    s_req_fire = 1'b0; s_resp_fire = 1'b0; s_req_is_write = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req_fire = 1'b0; resp_fire = 1'b0; req_is_write = 1'b0;
    s_req_fire = 1'b0; s_resp_fire = 1'b0; s_req_is_write = 1'b0;

    // Reset state
    do_reset();
    chk("rst_cycle", global_cycle, 64'd0);
    chk("rst_valid", 64'(stat_valid), 64'd0);
    chk("rst_id", 64'(stat_req_id), 64'd0);
    chk("rst_lat", 64'(stat_latency), 64'd0);
    chk("rst_out", 64'(outstanding), 64'd0);
    chk("rst_max", 64'(max_latency), 64'd0);
    chk("rst_ovf", 64'(err_overflow), 64'd0);
    chk("rst_unf", 64'(err_underflow), 64'd0);

    // Single read: request at 5, response at 12
    step(5);
    chk("s1_gc5", global_cycle, 64'd5);
    req_fire = 1'b1; req_is_write = 1'b0;
    step(1);
    req_fire = 1'b0;
    chk("s1_out1", 64'(outstanding), 64'd1);
    step(6);
    resp_fire = 1'b1;
    step(1);
    resp_fire = 1'b0;
    chk("s1_gc13", global_cycle, 64'd13);
    chk("s1_valid", 64'(stat_valid), 64'd1);
    chk("s1_id", 64'(stat_req_id), 64'd0);
    chk("s1_rd", 64'(stat_rd_en), 64'd1);
    chk("s1_wr", 64'(stat_wr_en), 64'd0);
    chk("s1_cycle", stat_cycle, 64'd12);
    chk("s1_lat", 64'(stat_latency), 64'd7);
    chk("s1_max", 64'(max_latency), 64'd7);
    chk("s1_out0", 64'(outstanding), 64'd0);
    step(1);
    chk("s1_pulse_end", 64'(stat_valid), 64'd0);
    chk("s1_hold_cycle", stat_cycle, 64'd12);

    // Back-to-back W@3 R@4 W@5, responses @10,11,12
    do_reset();
    step(3);
    req_fire = 1'b1; req_is_write = 1'b1;
    step(1);
    req_is_write = 1'b0;
    step(1);
    req_is_write = 1'b1;
    step(1);
    req_fire = 1'b0;
    chk("s2_out3", 64'(outstanding), 64'd3);
    step(4);
    resp_fire = 1'b1;
    step(1);
    chk("s2_v0", 64'(stat_valid), 64'd1);
    chk("s2_id0", 64'(stat_req_id), 64'd0);
    chk("s2_wr0", 64'(stat_wr_en), 64'd1);
    chk("s2_cyc0", stat_cycle, 64'd10);
    chk("s2_lat0", 64'(stat_latency), 64'd7);
    chk("s2_out2", 64'(outstanding), 64'd2);
    step(1);
    chk("s2_v1", 64'(stat_valid), 64'd1);
    chk("s2_id1", 64'(stat_req_id), 64'd1);
    chk("s2_rd1", 64'(stat_rd_en), 64'd1);
    chk("s2_lat1", 64'(stat_latency), 64'd7);
    chk("s2_out1", 64'(outstanding), 64'd1);
    step(1);
    resp_fire = 1'b0;
    chk("s2_v2", 64'(stat_valid), 64'd1);
    chk("s2_id2", 64'(stat_req_id), 64'd2);
    chk("s2_wr2", 64'(stat_wr_en), 64'd1);
    chk("s2_cyc2", stat_cycle, 64'd12);
    chk("s2_lat2", 64'(stat_latency), 64'd7);
    chk("s2_out0", 64'(outstanding), 64'd0);
    chk("s2_max", 64'(max_latency), 64'd7);

    // Full, then overflow, then simultaneous push/pop while full
    do_reset();
    req_fire = 1'b1; req_is_write = 1'b0;
    step(16);
    chk("s3_out16", 64'(outstanding), 64'd16);
    chk("s3_no_ovf", 64'(err_overflow), 64'd0);
    step(1);
    chk("s3_ovf", 64'(err_overflow), 64'd1);
    chk("s3_out_hold", 64'(outstanding), 64'd16);
    resp_fire = 1'b1;
    step(1);
    req_fire = 1'b0; resp_fire = 1'b0;
    chk("s3_valid", 64'(stat_valid), 64'd1);
    chk("s3_id", 64'(stat_req_id), 64'd0);
    chk("s3_cycle", stat_cycle, 64'd17);
    chk("s3_lat", 64'(stat_latency), 64'd17);
    chk("s3_out15", 64'(outstanding), 64'd15);
    chk("s3_ovf_sticky", 64'(err_overflow), 64'd1);

    // Empty with simultaneous push/pop
    do_reset();
    chk("s4_ovf_clr", 64'(err_overflow), 64'd0);
    step(2);
    req_fire = 1'b1; req_is_write = 1'b1; resp_fire = 1'b1;
    step(1);
    req_fire = 1'b0; resp_fire = 1'b0;
    chk("s4_unf", 64'(err_underflow), 64'd1);
    chk("s4_no_valid", 64'(stat_valid), 64'd0);
    chk("s4_out1", 64'(outstanding), 64'd1);
    chk("s4_no_ovf", 64'(err_overflow), 64'd0);
    step(3);
    resp_fire = 1'b1;
    step(1);
    resp_fire = 1'b0;
    chk("s4_valid", 64'(stat_valid), 64'd1);
    chk("s4_id", 64'(stat_req_id), 64'd0);
    chk("s4_wr", 64'(stat_wr_en), 64'd1);
    chk("s4_cycle", stat_cycle, 64'd6);
    chk("s4_lat", 64'(stat_latency), 64'd4);

    // Saturation on the LAT_W=4 instance
    do_reset();
    chk("s5_unf_clr", 64'(err_underflow), 64'd0);
    s_req_fire = 1'b1;
    step(1);
    s_req_fire = 1'b0;
    step(19);
    chk("s5_gc20", s_global_cycle, 64'd20);
    s_resp_fire = 1'b1;
    step(1);
    s_resp_fire = 1'b0;
    chk("s5_valid", 64'(s_stat_valid), 64'd1);
    chk("s5_cycle", s_stat_cycle, 64'd20);
    chk("s5_lat_sat", 64'(s_stat_latency), 64'd15);
    chk("s5_max_sat", 64'(s_max_latency), 64'd15);
    s_req_fire = 1'b1;
    step(1);
    s_req_fire = 1'b0;
    step(13);
    s_resp_fire = 1'b1;
    step(1);
    s_resp_fire = 1'b0;
    chk("s5_id1", 64'(s_stat_req_id), 64'd1);
    chk("s5_lat14", 64'(s_stat_latency), 64'd14);
    chk("s5_max_keep", 64'(s_max_latency), 64'd15);

    // Reset mid-flight with 3 outstanding
    do_reset();
    req_fire = 1'b1; req_is_write = 1'b0;
    step(4);
    req_fire = 1'b0; resp_fire = 1'b1;
    step(1);
    resp_fire = 1'b0;
    chk("s6_id0", 64'(stat_req_id), 64'd0);
    chk("s6_lat", 64'(stat_latency), 64'd4);
    chk("s6_out3", 64'(outstanding), 64'd3);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("s6_gc0", global_cycle, 64'd0);
    chk("s6_out0", 64'(outstanding), 64'd0);
    chk("s6_valid0", 64'(stat_valid), 64'd0);
    chk("s6_max0", 64'(max_latency), 64'd0);
    chk("s6_cyc0", stat_cycle, 64'd0);
    step(3);
    chk("s6_quiet", 64'(stat_valid), 64'd0);
    chk("s6_quiet_out", 64'(outstanding), 64'd0);
    req_fire = 1'b1;
    step(1);
    req_fire = 1'b0;
    step(1);
    resp_fire = 1'b1;
    step(1);
    resp_fire = 1'b0;
    chk("s6_new_valid", 64'(stat_valid), 64'd1);
    chk("s6_new_id", 64'(stat_req_id), 64'd0);
    chk("s6_new_cycle", stat_cycle, 64'd5);
    chk("s6_new_lat", 64'(stat_latency), 64'd2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
